// File: rtl/alu_md.sv
// Execute-stage arithmetic block: a combinational ALU plus a multi-cycle
// multiply/divide unit that owns the HI/LO registers.
module alu_md #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           A,
    input  logic [WIDTH-1:0]           B,
    input  logic [$clog2(WIDTH)-1:0]   Shamt,
    input  logic [3:0]                 ALUOp,
    output logic [WIDTH-1:0]           C,
    output logic                       Zero,
    output logic                       Overflow,
    input  logic [2:0]                 MDOp,
    input  logic                       Start,
    output logic                       Busy,
    output logic [WIDTH-1:0]           HI,
    output logic [WIDTH-1:0]           LO
);
    localparam int SW         = $clog2(WIDTH);
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam int HALF       = WIDTH / 2;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SW-1:0]    var_amt;

    assign sum     = A + B;
    assign diff    = A - B;
    assign var_amt = A[SW-1:0];

    always_comb begin
        C = '0;
        case (ALUOp)
            4'd0:    C = sum;
            4'd1:    C = diff;
            4'd2:    C = A | B;
            4'd3:    C = A & B;
            4'd4:    C = A ^ B;
            4'd5:    C = ~(A | B);
            4'd6:    C = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            4'd7:    C = {{(WIDTH-1){1'b0}}, A < B};
            4'd8:    C = B << Shamt;
            4'd9:    C = B >> Shamt;
            4'd10:   C = $signed(B) >>> Shamt;
            4'd11:   C = B << var_amt;
            4'd12:   C = B >> var_amt;
            4'd13:   C = $signed(B) >>> var_amt;
            4'd14:   C = B << HALF;
            default: C = '0;
        endcase
    end

    assign Zero = (C == '0);

    always_comb begin
        Overflow = 1'b0;
        case (ALUOp)
            4'd0:    Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            4'd1:    Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            default: Overflow = 1'b0;
        endcase
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic               signed_op;
    logic               is_div;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   min_val;
    logic               div_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   sq;
    logic [WIDTH-1:0]   sr;
    logic [WIDTH-1:0]   uq;
    logic [WIDTH-1:0]   ur;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // One multiplier serves both mult and multu: the low 2*WIDTH bits of the
    // product of the extended operands are correct for either signedness.
    assign signed_op = ~op_q[0];
    assign is_div    = op_q[1];
    assign ext_a     = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b     = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign product   = ext_a * ext_b;

    // Divide-by-zero and MIN/-1 are resolved explicitly, so the divider is
    // fed a harmless divisor of 1 in those cases.
    assign min_val  = {1'b1, {(WIDTH-1){1'b0}}};
    assign div_zero = (b_q == '0);
    assign div_ovf  = signed_op && (a_q == min_val) && (b_q == '1);
    assign divisor  = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
    assign sq       = $signed(a_q) / $signed(divisor);
    assign sr       = $signed(a_q) % $signed(divisor);
    assign uq       = a_q / divisor;
    assign ur       = a_q % divisor;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (!is_div) begin
            {res_hi, res_lo} = product;
        end else if (div_zero) begin
            res_hi = a_q;
            res_lo = '1;
        end else if (div_ovf) begin
            res_hi = '0;
            res_lo = min_val;
        end else if (signed_op) begin
            res_hi = sr;
            res_lo = sq;
        end else begin
            res_hi = ur;
            res_lo = uq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            Busy  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                a_q   <= A;
                                b_q   <= B;
                                op_q  <= MDOp[1:0];
                                count <= MDOp[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                                state <= RUN;
                                Busy  <= 1'b1;
                            end
                            3'd4:    HI <= A;
                            3'd5:    LO <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (count <= CW'(1)) begin
                        HI    <= res_hi;
                        LO    <= res_lo;
                        count <= '0;
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_md.sv
// Randomised self-checking bench for alu_md against a plain-arithmetic
// reference model of the ALU and the HI/LO mult/div results.
module tb_alu_md;
    localparam int W    = 32;
    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [4:0]    Shamt;
    logic [3:0]    ALUOp;
    logic [W-1:0]  C;
    logic          Zero;
    logic          Overflow;
    logic [2:0]    MDOp;
    logic          Start;
    logic          Busy;
    logic [W-1:0]  HI;
    logic [W-1:0]  LO;

    int            compared   = 0;
    int            mismatched = 0;
    logic [31:0]   hiModel;
    logic [31:0]   loModel;

    alu_md #(.WIDTH(W), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Shamt(Shamt), .ALUOp(ALUOp),
        .C(C), .Zero(Zero), .Overflow(Overflow), .MDOp(MDOp), .Start(Start),
        .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            4'd0:  return 32'(longint'(a) + longint'(b));
            4'd1:  return 32'(longint'(a) - longint'(b));
            4'd2:  return a | b;
            4'd3:  return a & b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return 32'(longint'(b) * (longint'(1) << sh));
            4'd9:  return 32'(longint'(b) / (longint'(1) << sh));
            4'd10: return 32'(sb >>> sh);
            4'd11: return 32'(longint'(b) * (longint'(1) << a[4:0]));
            4'd12: return 32'(longint'(b) / (longint'(1) << a[4:0]));
            4'd13: return 32'(sb >>> a[4:0]);
            4'd14: return 32'(longint'(b[15:0]) * 65536);
            default: return 32'd0;
        endcase
    endfunction

    // Overflow means the true signed result does not fit in 32 bits.
    function automatic logic ovfRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint s;
        longint lim;
        lim = longint'(1) << 31;
        if (op == 4'd0)      s = longint'($signed(a)) + longint'($signed(b));
        else if (op == 4'd1) s = longint'($signed(a)) - longint'($signed(b));
        else                 return 1'b0;
        return (s >= lim) || (s < -lim);
    endfunction

    function automatic logic [63:0] mdRef(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return 64'({32'd0, a}) * 64'({32'd0, b});
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa - q * sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
        logic [31:0] expC;
        ALUOp = op;
        A     = a;
        B     = b;
        Shamt = sh;
        #1;
        expC = aluRef(op, a, b, sh);
        checkOutput($sformatf("alu op%0d C a=%h b=%h sh=%0d", op, a, b, sh), 64'(C), 64'(expC));
        checkOutput($sformatf("alu op%0d Zero", op), 64'(Zero), 64'(expC == 32'd0));
        checkOutput($sformatf("alu op%0d Overflow", op), 64'(Overflow), 64'(ovfRef(op, a, b)));
    endtask

    // Entered and left one time unit after a rising edge; the start edge is
    // the next rising edge, and the task returns in the first idle cycle.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit collide, input string tag);
        logic [63:0] expv;
        int          n;
        MDOp  = op;
        A     = a;
        B     = b;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        expv  = mdRef(op, a, b);
        n     = op[1] ? DIVC : MULC;
        for (int i = 1; i <= n; i++) begin
            checkOutput($sformatf("%s busy c%0d", tag, i), 64'(Busy), 64'd1);
            checkOutput($sformatf("%s HI hold c%0d", tag, i), 64'(HI), 64'(hiModel));
            checkOutput($sformatf("%s LO hold c%0d", tag, i), 64'(LO), 64'(loModel));
            A = $urandom;
            B = $urandom;
            if (collide && i == 2) begin
                A     = 32'h0000_1234;
                MDOp  = 3'd5;
                Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        Start   = 1'b0;
        hiModel = expv[63:32];
        loModel = expv[31:0];
        checkOutput({tag, " busy done"}, 64'(Busy), 64'd0);
        checkOutput({tag, " HI"}, 64'(HI), 64'(hiModel));
        checkOutput({tag, " LO"}, 64'(LO), 64'(loModel));
    endtask

    task automatic mtOp(input logic [2:0] op, input logic [31:0] a, input string tag);
        MDOp  = op;
        A     = a;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        if (op == 3'd4) hiModel = a;
        if (op == 3'd5) loModel = a;
        checkOutput({tag, " HI"}, 64'(HI), 64'(hiModel));
        checkOutput({tag, " LO"}, 64'(LO), 64'(loModel));
        checkOutput({tag, " busy"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n   = 1'b0;
        Start   = 1'b0;
        MDOp    = 3'd0;
        A       = '0;
        B       = '0;
        Shamt   = '0;
        ALUOp   = '0;
        hiModel = '0;
        loModel = '0;
        #12;
        checkOutput("reset busy", 64'(Busy), 64'd0);
        checkOutput("reset HI", 64'(HI), 64'd0);
        checkOutput("reset LO", 64'(LO), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0);
        checkOutput("plan add C", 64'(C), 64'h8000_0000);
        checkOutput("plan add ovf", 64'(Overflow), 64'd1);
        applyStimulus(4'd1, 32'd5, 32'd5, 5'd0);
        checkOutput("plan sub zero", 64'(Zero), 64'd1);
        applyStimulus(4'd6, 32'hFFFF_FFFF, 32'd1, 5'd0);
        checkOutput("plan slt C", 64'(C), 64'd1);
        applyStimulus(4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0);
        checkOutput("plan sltu C", 64'(C), 64'd0);
        applyStimulus(4'd10, 32'd0, 32'h8000_0000, 5'd4);
        checkOutput("plan sra C", 64'(C), 64'hF800_0000);
        applyStimulus(4'd1, 32'h8000_0000, 32'd1, 5'd0);
        applyStimulus(4'd14, 32'd0, 32'h1234_ABCD, 5'd0);
        checkOutput("plan lui C", 64'(C), 64'hABCD_0000);
        for (int i = 0; i < 120; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
                          5'($urandom));
        end

        @(posedge clk);
        #1;
        runOp(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult -2*3");
        checkOutput("plan mult HI", 64'(HI), 64'hFFFF_FFFF);
        checkOutput("plan mult LO", 64'(LO), 64'hFFFF_FFFA);
        runOp(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div -7/2");
        checkOutput("plan div LO", 64'(LO), 64'hFFFF_FFFD);
        runOp(3'd3, 32'd7, 32'd0, 1'b0, "divu 7/0");
        runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div min/-1");
        runOp(3'd2, 32'h0000_0009, 32'd0, 1'b0, "div 9/0");
        runOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu collide");
        mtOp(3'd4, 32'hDEAD_BEEF, "mthi");
        checkOutput("mthi busy next", 64'(Busy), 64'd0);
        mtOp(3'd5, 32'h0BAD_F00D, "mtlo");
        mtOp(3'd6, 32'h5555_5555, "nop6");

        for (int i = 0; i < 14; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (rop >= 3'd4) mtOp(rop, ra, $sformatf("rnd%0d mt%0d", i, rop));
            else             runOp(rop, ra, rb, i[0], $sformatf("rnd%0d md%0d", i, rop));
        end

        MDOp  = 3'd2;
        A     = 32'd100;
        B     = 32'd7;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        hiModel = '0;
        loModel = '0;
        checkOutput("midrun reset busy", 64'(Busy), 64'd0);
        checkOutput("midrun reset HI", 64'(HI), 64'd0);
        checkOutput("midrun reset LO", 64'(LO), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("held reset busy", 64'(Busy), 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runOp(3'd0, 32'd12345, 32'hFFFF_FF00, 1'b0, "mult after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/alu_md.md
# alu_md

Parametrised execute-stage arithmetic block: a combinational ALU with add, sub, logic, compare and shift operations and zero/overflow flags, plus a sequential multiply/divide unit with HI/LO registers and a busy flag. Sits in the EX stage of the pipelined MIPS core. The controller stalls instructions that touch HI/LO while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, datapath width in bits; must be ≥ 8
- `MUL_CYCLES`, 5, busy cycles for mult/multu; must be ≥ 1
- `DIV_CYCLES`, 10, busy cycles for div/divu; must be ≥ 1

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `A`  in  WIDTH  operand A (rs)
- `B`  in  WIDTH  operand B (rt or extended immediate)
- `Shamt`  in  log2(WIDTH)  shift amount
- `ALUOp`  in  4  ALU select; encoding under Operation
- `C`  out  WIDTH  ALU result (combinational)
- `Zero`  out  1  `C == 0`
- `Overflow`  out  1  signed overflow of add/sub; 0 for all other ops
- `MDOp`  in  3  mult/div select; encoding under Operation
- `Start`  in  1  one-cycle request to run `MDOp` with `A`/`B`
- `Busy`  out  1  mult/div operation in flight
- `HI`  out  WIDTH  HI register
- `LO`  out  WIDTH  LO register

## Operation
- ALU encodings (pure combinational):
  - 0 add (wrapping)
  - 1 sub
  - 2 or
  - 3 and
  - 4 xor
  - 5 nor
  - 6 slt (signed, result 0/1)
  - 7 sltu
  - 8 sll `B<<Shamt`
  - 9 srl
  - 10 sra
  - 11 sllv (amount = `A[log2(WIDTH)-1:0]`)
  - 12 srlv
  - 13 srav
  - 14 lui `{B[WIDTH/2-1:0], WIDTH/2 zeros}`
  - 15 outputs 0
- `Overflow`:
  - add: operand signs equal and result sign differs
  - sub: operand signs differ and result sign differs from A
  - 0 for every other op
- MD encodings:
  - 0 mult (signed)
  - 1 multu
  - 2 div (signed)
  - 3 divu
  - 4 mthi (HI←A)
  - 5 mtlo (LO←A)
  - 6, 7 no-op
- Multiply: 2·WIDTH-bit product; `HI` = upper half, `LO` = lower half.
- Divide:
  - `LO` = quotient truncated toward zero, `HI` = remainder with the sign of the dividend.
  - Signed MIN/−1: `LO` = MIN, `HI` = 0.
  - Divide by zero (B==0): `HI` = A, `LO` = all ones, for both div and divu. Full busy latency still applies.
- FSM:
  - States: IDLE, RUN.
  - IDLE → RUN on `Start` with MDOp 0–3. At that edge, capture operands, op and load the cycle counter (`MUL_CYCLES` or `DIV_CYCLES`).
  - RUN decrements the counter each edge. On the edge where it reaches the last cycle: write HI/LO, return to IDLE.
  - mthi/mtlo with `Start` in IDLE write at that edge and stay in IDLE; `Busy` never rises.
  - `Start` while RUN is ignored entirely: no capture, no HI/LO change, no restart.
  - `Start` with MDOp 6/7 is ignored.
- Operands are captured at start, so `A`/`B` may change freely while busy.

## Timing
- Reset (asynchronous assert, any time including mid-operation):
  - FSM → IDLE, `Busy`=0, `HI`=0, `LO`=0.
  - In-flight result is discarded; the counter is cleared.
- ALU outputs `C`, `Zero`, `Overflow` respond in the same cycle as their inputs; no register.
- `Start` sampled at edge t (IDLE):
  - `Busy`=1 during cycles t+1 … t+N (N = `MUL_CYCLES` or `DIV_CYCLES`).
  - HI/LO are updated at the edge ending cycle t+N.
  - At cycle t+N+1, `Busy`=0 and the new HI/LO are visible; a new `Start` is accepted at that edge.
- mthi/mtlo: the new value is visible in the cycle after the `Start` edge.
- HI/LO hold their old values throughout RUN.

## Test plan
- ALU sweep:
  - A=0x7FFFFFFF, B=1, add → C=0x80000000, Overflow=1, Zero=0.
  - A=5, B=5, sub → C=0, Zero=1.
  - A=0xFFFFFFFF, B=1, slt → C=1; sltu → C=0.
  - B=0x80000000, Shamt=4, sra → C=0xF8000000.
- Signed multiply: A=0xFFFFFFFE (−2), B=3, mult, Start at t → Busy high exactly 5 cycles; at t+6, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Divide:
  - A=−7, B=2, div → after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A=7, B=0, divu → HI=7, LO=0xFFFFFFFF.
  - A=0x80000000, B=0xFFFFFFFF, div → LO=0x80000000, HI=0.
- Busy collision:
  - During RUN, pulse Start with mtlo A=0x1234 → ignored; LO ends with the multiply result only.
  - Change A/B mid-run → result uses the captured operands.
- mthi/mtlo from IDLE:
  - A=0xDEADBEEF, mthi → HI=0xDEADBEEF next cycle, Busy stays 0.
  - Back-to-back Start on the first idle cycle after completion is accepted.
- Reset mid-run: deassert rst_n asynchronously at cycle 3 of a div → Busy, HI, LO = 0 immediately. After release, a new mult completes normally with correct latency.
